// File: rtl/alu.sv
// 32-bit registered ALU: result on C one clock after A/B/ALUOp are sampled.
// Define ALU_FLAGS_EN to add the registered zero and signed-overflow flags.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C
`ifdef ALU_FLAGS_EN
  ,
  output logic        zero,
  output logic        ovf
`endif
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic [31:0] r_c;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_shamt = B[4:0];

  always_comb begin
    w_result = '0;
    case (ALUOp)
      3'b000:  w_result = w_sum;
      3'b001:  w_result = w_diff;
      3'b010:  w_result = A & B;
      3'b011:  w_result = A | B;
      3'b100:  w_result = A >> w_shamt;
      3'b101:  w_result = 32'($signed(A) >>> w_shamt);
      3'b110:  w_result = {31'b0, $signed(A) < $signed(B)};
      3'b111:  w_result = {31'b0, A < B};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
    end else begin
      r_c <= w_result;
    end
  end

  assign C = r_c;

`ifdef ALU_FLAGS_EN
  logic w_ovf;
  logic r_zero;
  logic r_ovf;

  // Overflow only when the operands' signs make the result sign impossible.
  always_comb begin
    w_ovf = 1'b0;
    case (ALUOp)
      3'b000:  w_ovf = (A[31] == B[31]) && (w_sum[31] != A[31]);
      3'b001:  w_ovf = (A[31] != B[31]) && (w_diff[31] != A[31]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
      r_ovf  <= 1'b0;
    end else begin
      r_zero <= (w_result == '0);
      r_ovf  <= w_ovf;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard of expected results, one task per scenario.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  typedef struct {
    logic [31:0] c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .C     (C)
`ifdef ALU_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written bit-level, independent of the DUT's formulation.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    e.c = '0;
    e.v = 1'b0;
    case (op)
      3'd0: e.c = a + b;
      3'd1: e.c = a + ~b + 32'd1;
      3'd2: e.c = a & b;
      3'd3: e.c = a | b;
      3'd4: e.c = a >> b[4:0];
      3'd5: begin
        e.c = a;
        for (int i = 0; i < int'(b[4:0]); i++) e.c = {e.c[31], e.c[31:1]};
      end
      3'd6: e.c = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      3'd7: e.c = {31'b0, a < b};
      default: e.c = '0;
    endcase
    if (op == 3'd0) e.v = (a[31] == b[31]) && (e.c[31] != a[31]);
    if (op == 3'd1) e.v = (a[31] != b[31]) && (e.c[31] != a[31]);
    e.z = (e.c == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    A = a;
    B = b;
    ALUOp = op;
    sb.push_back(model(a, b, op));
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    A = 32'd5;
    B = 32'd3;
    ALUOp = 3'b000;
    #2;
    checks++;
    if (C !== 32'd0) begin failures++; $display("FAIL reset_c: C=%h expected 00000000", C); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL reset_flags: zero=%b ovf=%b expected 1 0", zero, ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{c: 32'd8, z: 1'b0, v: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (C !== e.c) begin failures++; $display("FAIL reset_release: C=%h expected %h", C, e.c); end
  endtask

  task automatic test_vectors(input string name, input logic [31:0] av[], input logic [31:0] bv[],
                              input logic [2:0] ov[], input logic [31:0] cv[]);
    exp_t e;
    for (int i = 0; i < av.size(); i++) begin
      drive(av[i], bv[i], ov[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (C !== e.c || C !== cv[i]) begin
        failures++;
        $display("FAIL %s[%0d]: C=%h expected %h", name, i, C, cv[i]);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (zero !== e.z || ovf !== e.v) begin
        failures++;
        $display("FAIL %s_flags[%0d]: zero=%b ovf=%b expected %b %b", name, i, zero, ovf, e.z, e.v);
      end
`endif
    end
  endtask

  task automatic test_arith;
    test_vectors("arith",
      '{32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000},
      '{32'h1, 32'h1, 32'h1, 32'h1},
      '{3'b000, 3'b001, 3'b000, 3'b001},
      '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF});
  endtask

  task automatic test_logic;
    test_vectors("logic",
      '{32'hF0F0_F0F0, 32'hF0F0_F0F0},
      '{32'h0FF0_0FF0, 32'h0FF0_0FF0},
      '{3'b010, 3'b011},
      '{32'h00F0_00F0, 32'hFFF0_FFF0});
  endtask

  task automatic test_shift;
    test_vectors("shift",
      '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001, 32'h4000_0000},
      '{32'd4, 32'd4, 32'h24, 32'h24, 32'd0, 32'd0, 32'd31},
      '{3'b100, 3'b101, 3'b100, 3'b101, 3'b100, 3'b101, 3'b101},
      '{32'h0800_0000, 32'hF800_0000, 32'h0800_0000, 32'hF800_0000, 32'h8000_0001, 32'h8000_0001, 32'h0});
  endtask

  task automatic test_compare;
    test_vectors("compare",
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd3},
      '{32'd1, 32'd1, 32'd7, 32'd7, 32'hFFFF_FFFE},
      '{3'b110, 3'b111, 3'b110, 3'b111, 3'b111},
      '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1});
  endtask

  task automatic test_back_to_back;
    logic [31:0] want [8] = '{32'd17, 32'd7, 32'd4, 32'd13, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t e;
    @(negedge clk);
    A = 32'd12;
    B = 32'd5;
    for (int op = 0; op < 8; op++) begin
      ALUOp = 3'(op);
      sb.push_back(model(32'd12, 32'd5, 3'(op)));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (C !== want[op] || C !== e.c) begin
        failures++;
        $display("FAIL latency[%0d]: C=%0d expected %0d", op, C, want[op]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold;
    exp_t e;
    drive(32'd100, 32'd1, 3'b000);
    @(posedge clk); #1;
    e = sb.pop_front();
    #2;
    A = 32'd7;
    B = 32'd7;
    ALUOp = 3'b001;
    sb.push_back(model(32'd7, 32'd7, 3'b001));
    #5;
    checks++;
    if (C !== 32'd101 || C !== e.c) begin failures++; $display("FAIL hold: C=%0d expected 101", C); end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (C !== 32'd0 || C !== e.c) begin failures++; $display("FAIL hold_next: C=%0d expected 0", C); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL hold_zero: zero=%b expected 1", zero); end
`endif
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    drive(32'd1, 32'd2, 3'b000);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (C !== e.c) begin failures++; $display("FAIL mid_pre: C=%h expected %h", C, e.c); end
    @(negedge clk);
    A = 32'h7FFF_FFFF;
    B = 32'd1;
    ALUOp = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (C !== 32'd0) begin failures++; $display("FAIL mid_async: C=%h expected 00000000", C); end
    @(posedge clk); #1;
    checks++;
    if (C !== 32'd0) begin failures++; $display("FAIL mid_held: C=%h expected 00000000", C); end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL mid_flags: zero=%b ovf=%b expected 1 0", zero, ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    A = 32'd5;
    B = 32'd3;
    ALUOp = 3'b000;
    sb.push_back(model(32'd5, 32'd3, 3'b000));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (C !== 32'd8 || C !== e.c) begin failures++; $display("FAIL mid_release: C=%0d expected 8", C); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_shift;
    test_compare;
    test_back_to_back;
    test_hold;
    test_reset_midstream;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
